// File: rtl/ped_crossing_unit.sv
// Pedestrian-side companion to the intersection controller: debounces the crossing
// buttons, holds requests until granted, and sequences WALK / flashing DON'T-WALK.
module ped_crossing_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WALK_CYCLES     = 6,
    parameter int unsigned FLASH_CYCLES    = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ns,
    input  logic       btn_ew,
    input  logic [2:0] signal_ns,
    input  logic [2:0] signal_ew,
    input  logic       grant_ns,
    input  logic       grant_ew,
    output logic       req_ns,
    output logic       req_ew,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       dont_walk_ns,
    output logic       dont_walk_ew,
    output logic       fault
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WALK  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [2:0] LAMP_RED   = 3'b100;
    localparam logic [2:0] LAMP_YEL   = 3'b010;
    localparam logic [2:0] LAMP_GREEN = 3'b001;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);

    function automatic logic lamp_bad(input logic [2:0] s);
        return !((s == LAMP_RED) || (s == LAMP_YEL) || (s == LAMP_GREEN));
    endfunction

    logic       fault_q;
    logic       fault_d;
    logic       fault_cond;
    logic [1:0] btn_v;
    logic [1:0] grant_v;
    logic [1:0] safe_v;
    logic [1:0] req_v;
    logic [1:0] walk_v;
    logic [1:0] dw_v;

    // Index 0 is NS, index 1 is EW; each crosses only while cross traffic is red.
    assign btn_v   = {btn_ew, btn_ns};
    assign grant_v = {grant_ew, grant_ns};
    assign safe_v  = {(signal_ns == LAMP_RED), (signal_ew == LAMP_RED)};

    always_comb begin
        fault_cond = lamp_bad(signal_ns) || lamp_bad(signal_ew) ||
                     ((signal_ns == LAMP_GREEN) && (signal_ew == LAMP_GREEN));
        fault_d    = fault_q || fault_cond;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

    for (genvar i = 0; i < 2; i++) begin : g_dir
        logic             sync1_q;
        logic             sync2_q;
        logic             db_q;
        logic             db_d;
        logic [CNT_W-1:0] db_cnt_q;
        logic [CNT_W-1:0] db_cnt_d;
        logic             press;
        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic [CNT_W-1:0] ph_cnt_q;
        logic [CNT_W-1:0] ph_cnt_d;
        logic             pend_q;
        logic             pend_d;
        logic             req_q;
        logic             req_d;
        logic             walk_q;
        logic             walk_d;
        logic             dw_q;
        logic             dw_d;

        // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            db_d     = db_q;
            db_cnt_d = '0;
            press    = 1'b0;
            if (sync2_q != db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_d  = ~db_q;
                    press = ~db_q;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
        end

        // A fault parks the crossing dark-safe but still latches new requests.
        always_comb begin
            state_d  = state_q;
            ph_cnt_d = ph_cnt_q;
            pend_d   = pend_q;
            req_d    = req_q;
            walk_d   = walk_q;
            dw_d     = dw_q;
            if (fault_d) begin
                state_d  = ST_IDLE;
                ph_cnt_d = '0;
                pend_d   = 1'b0;
                walk_d   = 1'b0;
                dw_d     = 1'b1;
                req_d    = req_q || press;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        walk_d = 1'b0;
                        dw_d   = 1'b1;
                        if (press) begin
                            state_d = ST_REQ;
                            req_d   = 1'b1;
                        end
                    end
                    ST_REQ: begin
                        req_d = 1'b1;
                        dw_d  = 1'b1;
                        if (grant_v[i] && safe_v[i]) begin
                            state_d  = ST_WALK;
                            req_d    = 1'b0;
                            walk_d   = 1'b1;
                            dw_d     = 1'b0;
                            ph_cnt_d = '0;
                        end
                    end
                    ST_WALK: begin
                        pend_d = pend_q || press;
                        if (!grant_v[i] || !safe_v[i] || (ph_cnt_q == WALK_LAST)) begin
                            state_d  = ST_CLEAR;
                            walk_d   = 1'b0;
                            dw_d     = 1'b1;
                            ph_cnt_d = '0;
                        end else begin
                            ph_cnt_d = ph_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_CLEAR: begin
                        if (ph_cnt_q == FLASH_LAST) begin
                            dw_d     = 1'b1;
                            ph_cnt_d = '0;
                            pend_d   = 1'b0;
                            if (pend_q || press) begin
                                state_d = ST_REQ;
                                req_d   = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            ph_cnt_d = ph_cnt_q + CNT_W'(1);
                            dw_d     = ~dw_q;
                            pend_d   = pend_q || press;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        ph_cnt_d = '0;
                        walk_d   = 1'b0;
                        dw_d     = 1'b1;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                db_q     <= 1'b0;
                db_cnt_q <= '0;
                state_q  <= ST_IDLE;
                ph_cnt_q <= '0;
                pend_q   <= 1'b0;
                req_q    <= 1'b0;
                walk_q   <= 1'b0;
                dw_q     <= 1'b1;
            end else begin
                sync1_q  <= btn_v[i];
                sync2_q  <= sync1_q;
                db_q     <= db_d;
                db_cnt_q <= db_cnt_d;
                state_q  <= state_d;
                ph_cnt_q <= ph_cnt_d;
                pend_q   <= pend_d;
                req_q    <= req_d;
                walk_q   <= walk_d;
                dw_q     <= dw_d;
            end
        end

        assign req_v[i]  = req_q;
        assign walk_v[i] = walk_q;
        assign dw_v[i]   = dw_q;
    end

    assign req_ns       = req_v[0];
    assign req_ew       = req_v[1];
    assign walk_ns      = walk_v[0];
    assign walk_ew      = walk_v[1];
    assign dont_walk_ns = dw_v[0];
    assign dont_walk_ew = dw_v[1];

endmodule

// File: tb/tb_ped_crossing_unit.sv
// Self-checking bench for ped_crossing_unit: one vector per clock, expected
// outputs queued at drive time and compared one time unit after the edge.
module tb_ped_crossing_unit;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Output order: req_ns req_ew walk_ns walk_ew dont_walk_ns dont_walk_ew fault
    localparam logic [6:0] O_IDLE = 7'b0000110;
    localparam logic [6:0] O_RNS  = 7'b1000110;
    localparam logic [6:0] O_WNS  = 7'b0010010;
    localparam logic [6:0] O_DW0  = 7'b0000010;
    localparam logic [6:0] O_F    = 7'b0000111;
    localparam logic [6:0] O_FREW = 7'b0100111;

    typedef struct {
        string      nm;
        logic       r;
        logic       bn;
        logic       be;
        logic [2:0] sn;
        logic [2:0] se;
        logic       gn;
        logic       ge;
        logic [6:0] ex;
    } vec_t;

    typedef struct {
        string      nm;
        logic [6:0] o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ns = 1'b0;
    logic       btn_ew = 1'b0;
    logic [2:0] signal_ns = R;
    logic [2:0] signal_ew = R;
    logic       grant_ns = 1'b0;
    logic       grant_ew = 1'b0;
    logic       req_ns;
    logic       req_ew;
    logic       walk_ns;
    logic       walk_ew;
    logic       dont_walk_ns;
    logic       dont_walk_ew;
    logic       fault;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ped_crossing_unit dut (
        .clk          (clk),
        .rst          (rst),
        .btn_ns       (btn_ns),
        .btn_ew       (btn_ew),
        .signal_ns    (signal_ns),
        .signal_ew    (signal_ew),
        .grant_ns     (grant_ns),
        .grant_ew     (grant_ew),
        .req_ns       (req_ns),
        .req_ew       (req_ew),
        .walk_ns      (walk_ns),
        .walk_ew      (walk_ew),
        .dont_walk_ns (dont_walk_ns),
        .dont_walk_ew (dont_walk_ew),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic bn, input logic be,
                       input logic [2:0] sn, input logic [2:0] se,
                       input logic gn, input logic ge, input logic [6:0] ex);
        vec_t v;
        v = '{nm: nm, r: r, bn: bn, be: be, sn: sn, se: se, gn: gn, ge: ge, ex: ex};
        tbl.push_back(v);
    endtask

    // Drive one cycle at the falling edge, queue its expectation, check after the rising edge.
    task automatic cyc(input string nm, input logic r, input logic bn, input logic be,
                       input logic [2:0] sn, input logic [2:0] se,
                       input logic gn, input logic ge, input logic [6:0] ex);
        exp_t       cur;
        logic [6:0] got;
        @(negedge clk);
        rst       = r;
        btn_ns    = bn;
        btn_ew    = be;
        signal_ns = sn;
        signal_ew = se;
        grant_ns  = gn;
        grant_ew  = ge;
        sb.push_back('{nm: nm, o: ex});
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            got = {req_ns, req_ew, walk_ns, walk_ew, dont_walk_ns, dont_walk_ew, fault};
            n_tests++;
            if (got !== cur.o) begin
                n_fail++;
                $display("FAIL %s: got %b required %b (req_ns req_ew walk_ns walk_ew dw_ns dw_ew fault)",
                         cur.nm, got, cur.o);
            end
        end
    endtask

    initial begin
        // Debounce latency, short EW glitch, unsafe grant, full walk and flash.
        add("A_rst",      1, 0, 0, R, R, 0, 0, O_IDLE);
        for (int k = 0; k < 3; k++) add("A_deb_glitch", 0, 1, 1, R, R, 0, 0, O_IDLE);
        for (int k = 0; k < 2; k++) add("A_deb",        0, 1, 0, R, R, 0, 0, O_IDLE);
        add("A_press",    0, 1, 0, R, R, 0, 0, O_RNS);
        add("A_unsafe",   0, 0, 0, R, G, 1, 0, O_RNS);
        for (int k = 0; k < 6; k++) add("A_walk",       0, 0, 0, R, R, 1, 0, O_WNS);
        add("A_flash1",   0, 0, 0, R, R, 0, 0, O_IDLE);
        add("A_flash0",   0, 0, 0, R, R, 0, 0, O_DW0);
        add("A_flash1b",  0, 0, 0, R, R, 0, 0, O_IDLE);
        add("A_flash0b",  0, 0, 0, R, R, 0, 0, O_DW0);
        add("A_idle",     0, 0, 0, R, R, 0, 0, O_IDLE);
        add("A_idle2",    0, 0, 0, R, R, 0, 0, O_IDLE);

        foreach (tbl[k])
            cyc(tbl[k].nm, tbl[k].r, tbl[k].bn, tbl[k].be, tbl[k].sn, tbl[k].se,
                tbl[k].gn, tbl[k].ge, tbl[k].ex);

        // Pending: second press lands during WALK, REQ follows the flash unprompted.
        cyc("B_rst", 1, 0, 0, R, R, 0, 0, O_IDLE);
        for (int k = 0; k < 5; k++) cyc("B_deb", 0, 1, 0, R, R, 0, 0, O_IDLE);
        cyc("B_press", 0, 1, 0, R, R, 0, 0, O_RNS);
        for (int k = 0; k < 6; k++) cyc("B_release", 0, 0, 0, R, R, 0, 0, O_RNS);
        for (int k = 0; k < 3; k++) cyc("B_repress", 0, 1, 0, R, R, 0, 0, O_RNS);
        for (int k = 0; k < 6; k++) cyc("B_walk", 0, 1, 0, R, R, 1, 0, O_WNS);
        cyc("B_flash1",  0, 1, 0, R, R, 1, 0, O_IDLE);
        cyc("B_flash0",  0, 1, 0, R, R, 0, 0, O_DW0);
        cyc("B_flash1b", 0, 1, 0, R, R, 0, 0, O_IDLE);
        cyc("B_flash0b", 0, 1, 0, R, R, 0, 0, O_DW0);
        cyc("B_pend_req", 0, 1, 0, R, R, 0, 0, O_RNS);
        cyc("B_pend_hold", 0, 1, 0, R, R, 0, 0, O_RNS);
        cyc("B_pend_walk", 0, 1, 0, R, R, 1, 0, O_WNS);

        // Early abort when EW leaves red on WALK cycle 3; press+grant same edge in IDLE.
        cyc("C_rst", 1, 0, 0, R, R, 0, 0, O_IDLE);
        for (int k = 0; k < 5; k++) cyc("C_deb", 0, 1, 0, R, R, 1, 0, O_IDLE);
        cyc("C_press_grant", 0, 1, 0, R, R, 1, 0, O_RNS);
        for (int k = 0; k < 3; k++) cyc("C_walk", 0, 0, 0, R, R, 1, 0, O_WNS);
        cyc("C_abort",    0, 0, 0, R, Y, 1, 0, O_IDLE);
        cyc("C_flash0",   0, 0, 0, R, Y, 1, 0, O_DW0);
        cyc("C_flash1",   0, 0, 0, R, Y, 1, 0, O_IDLE);
        cyc("C_flash0b",  0, 0, 0, R, Y, 1, 0, O_DW0);
        cyc("C_idle",     0, 0, 0, R, Y, 1, 0, O_IDLE);
        cyc("C_idle2",    0, 0, 0, R, Y, 1, 0, O_IDLE);

        // Sticky fault: requests still latch, grants ignored, reset clears it.
        cyc("D_rst", 1, 0, 0, R, R, 0, 0, O_IDLE);
        cyc("D_bad_ns", 0, 0, 0, 3'b011, R, 0, 0, O_F);
        for (int k = 0; k < 5; k++) cyc("D_sticky", 0, 0, 1, R, R, 0, 0, O_F);
        cyc("D_req_ew", 0, 0, 1, R, R, 0, 0, O_FREW);
        for (int k = 0; k < 3; k++) cyc("D_grant_ignored", 0, 0, 1, R, R, 0, 1, O_FREW);
        cyc("D_rst_clear", 1, 0, 0, R, R, 0, 0, O_IDLE);
        cyc("D_after", 0, 0, 0, R, R, 0, 0, O_IDLE);

        cyc("D2_rst", 1, 0, 0, R, R, 0, 0, O_IDLE);
        cyc("D2_both_green", 0, 0, 0, G, G, 0, 0, O_F);
        cyc("D2_sticky", 0, 0, 0, R, R, 0, 0, O_F);

        // Reset in the middle of WALK.
        cyc("E_rst", 1, 0, 0, R, R, 0, 0, O_IDLE);
        for (int k = 0; k < 5; k++) cyc("E_deb", 0, 1, 0, R, R, 1, 0, O_IDLE);
        cyc("E_press", 0, 1, 0, R, R, 1, 0, O_RNS);
        cyc("E_walk",  0, 0, 0, R, R, 1, 0, O_WNS);
        cyc("E_walk2", 0, 0, 0, R, R, 1, 0, O_WNS);
        cyc("E_rst_mid", 1, 0, 0, R, R, 1, 0, O_IDLE);
        for (int k = 0; k < 3; k++) cyc("E_after", 0, 0, 0, R, R, 1, 0, O_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
